sipo_rx_controller: RTL and testbench
=====================================

SIPO_RX_CONTROLLER -- requirements
Module: sipo_rx_controller

Interface
REQ-001 Parameter WORD_WIDTH, default 32, bits per assembled word.
REQ-002 Parameter MSB_FIRST, default 1, selects the shift direction: 1 means the first received bit lands in bit WORD_WIDTH-1; 0 means it lands in bit 0.
REQ-003 Clk_In  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset_In  input  1  reset, synchronous, active-high.
REQ-005 Frame_Start_In  input  1  start or restart a word assembly.
REQ-006 Continuous_In  input  1  when 1, begin the next word immediately after the current one completes.
REQ-007 Serial_Valid_In  input  1  qualifies Serial_Data_In for this cycle.
REQ-008 Serial_Data_In  input  1  serial bit.
REQ-009 Word_Ready_In  input  1  downstream accepts Word_Data_Out.
REQ-010 Word_Data_Out  output  WORD_WIDTH  assembled parallel word, held while Word_Valid_Out=1.
REQ-011 Word_Valid_Out  output  1  Word_Data_Out is valid.
REQ-012 Busy_Out  output  1  FSM is in SHIFT.
REQ-013 Bit_Count_Out  output  $clog2(WORD_WIDTH+1)  bits captured in the current word.
REQ-014 Overrun_Out  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-015 FSM states SHALL be IDLE and SHIFT, with a separate output holding register plus valid flag.
REQ-016 In IDLE with Frame_Start_In=1, the FSM SHALL go to SHIFT and clear the shift register and Bit_Count_Out; serial bits in that same cycle are ignored.
REQ-017 In SHIFT, when Serial_Valid_In=1, the block SHALL shift in Serial_Data_In and increment Bit_Count_Out. MSB_FIRST=1 uses {sr[W-2:0],bit}; MSB_FIRST=0 uses {bit,sr[W-1:1]}.
REQ-018 In SHIFT, a cycle with Serial_Valid_In=0 SHALL leave the shift register and count unchanged.
REQ-019 When the WORD_WIDTH-th valid bit is sampled at edge N:
 - the complete word (including that bit) SHALL be offered to the holding register at edge N.
 - Word_Valid_Out SHALL be high in the cycle after edge N.
 - Latency from the last bit to valid is 1 cycle.
REQ-020 At completion, Bit_Count_Out SHALL return to 0. The FSM SHALL stay in SHIFT if Continuous_In=1, otherwise return to IDLE.
REQ-021 Output handshake: a transfer SHALL occur at an edge where Word_Valid_Out=1 and Word_Ready_In=1. After a transfer, Word_Valid_Out SHALL deassert unless a new word loads at the same edge.
REQ-022 Word_Data_Out SHALL NOT change while Word_Valid_Out=1 and no transfer occurs.
REQ-023 Word completion and transfer at the same edge SHALL load the new word, keep Word_Valid_Out=1, and not flag overrun.
REQ-024 Word completion while Word_Valid_Out=1 and Word_Ready_In=0 SHALL:
 - discard the new word;
 - keep the old word;
 - pulse Overrun_Out for exactly one cycle.
REQ-025 Frame_Start_In=1 while in SHIFT SHALL abort the partial word (count to 0, register cleared) and stay in SHIFT. Serial data in that cycle is ignored, and Frame_Start_In takes priority over completion.
REQ-026 Frame_Start_In SHALL NOT affect the holding register or Word_Valid_Out.
REQ-027 Busy_Out SHALL equal 1 exactly when the FSM is in SHIFT.

Reset
REQ-028 With Reset_In=1 at an edge, the block SHALL set:
 - state to IDLE;
 - shift register, Word_Data_Out and Bit_Count_Out to 0;
 - Word_Valid_Out, Busy_Out and Overrun_Out to 0.
REQ-029 Reset mid-word or with a pending valid word SHALL discard both with no overrun pulse. Reset SHALL take priority over all other inputs.

Verification
REQ-030 Reset, Frame_Start_In pulse, then 32 valid bits of 0xA5C3_0F96 MSB-first -> Word_Data_Out=0xA5C30F96 and Word_Valid_Out=1 one cycle after the 32nd bit; Busy_Out=0 afterwards (Continuous_In=0).
REQ-031 MSB_FIRST=0, same bit stream -> Word_Data_Out equals the bit-reversed value 0x69F0C3A5.
REQ-032 Random Serial_Valid_In gaps (~50%) during a word -> correct word; Bit_Count_Out increments only on valid cycles.
REQ-033 Continuous_In=1 with Word_Ready_In=0 held across two words -> first word retained, Overrun_Out pulses once for one cycle at the second completion. Repeat with Word_Ready_In=1 at that edge -> second word loaded, no overrun.
REQ-034 Frame_Start_In asserted after 17 bits -> Bit_Count_Out=0 next cycle; the following 32 bits form the word, with no stale bits.
REQ-035 Reset_In asserted after 20 bits and with Word_Valid_Out=1 -> all outputs 0 on the next cycle; state IDLE.

Source files
------------

// File: rtl/sipo_rx_controller.sv
// Serial-in/parallel-out receive controller: assembles WORD_WIDTH serial
// bits into a word and offers it through a valid/ready holding register.
//
// Ports:
//   Clk_In          rising-edge clock
//   Reset_In        synchronous active-high reset
//   Frame_Start_In  start (IDLE) or restart (SHIFT) a word assembly
//   Continuous_In   stay in SHIFT after a word completes
//   Serial_Valid_In qualifies Serial_Data_In
//   Serial_Data_In  serial bit
//   Word_Ready_In   downstream accepts Word_Data_Out
//   Word_Data_Out   held parallel word
//   Word_Valid_Out  Word_Data_Out is valid
//   Busy_Out        FSM is in SHIFT
//   Bit_Count_Out   bits captured in the current word
//   Overrun_Out     one-cycle pulse when a completed word is dropped
module sipo_rx_controller #(
   parameter int WORD_WIDTH = 32,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                          Clk_In,
   input  logic                          Reset_In,
   input  logic                          Frame_Start_In,
   input  logic                          Continuous_In,
   input  logic                          Serial_Valid_In,
   input  logic                          Serial_Data_In,
   input  logic                          Word_Ready_In,
   output logic [WORD_WIDTH-1:0]         Word_Data_Out,
   output logic                          Word_Valid_Out,
   output logic                          Busy_Out,
   output logic [$clog2(WORD_WIDTH+1)-1:0] Bit_Count_Out,
   output logic                          Overrun_Out
);

   localparam int CW = $clog2(WORD_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e                state_q;
   logic [WORD_WIDTH-1:0] sr_q;
   logic [CW-1:0]         cnt_q;
   logic [WORD_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  ovr_q;

   logic [WORD_WIDTH-1:0] sr_d;
   logic                  done_d;
   logic                  xfer_d;

   always_comb begin
      sr_d = sr_q;
      if (MSB_FIRST) begin
         sr_d = {sr_q[WORD_WIDTH-2:0], Serial_Data_In};
      end else begin
         sr_d = {Serial_Data_In, sr_q[WORD_WIDTH-1:1]};
      end
      // Frame start wins over completion of the final bit
      done_d = (state_q == SHIFT) && !Frame_Start_In &&
               Serial_Valid_In && (cnt_q == LAST);
      xfer_d = valid_q && Word_Ready_In;
   end

   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (Frame_Start_In) begin
                  state_q <= SHIFT;
                  sr_q    <= '0;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               if (Frame_Start_In) begin
                  sr_q  <= '0;
                  cnt_q <= '0;
               end else if (Serial_Valid_In) begin
                  if (cnt_q == LAST) begin
                     sr_q    <= '0;
                     cnt_q   <= '0;
                     state_q <= Continuous_In ? SHIFT : IDLE;
                  end else begin
                     sr_q  <= sr_d;
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase

         // Holding register: a new word loads if the slot is empty or
         // drains at this same edge; otherwise it is dropped.
         if (done_d) begin
            if (!valid_q || Word_Ready_In) begin
               data_q  <= sr_d;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (xfer_d) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign Word_Data_Out  = data_q;
   assign Word_Valid_Out = valid_q;
   assign Busy_Out       = (state_q == SHIFT);
   assign Bit_Count_Out  = cnt_q;
   assign Overrun_Out    = ovr_q;

endmodule

// File: tb/tb_sipo_rx_controller.sv
// Bench for sipo_rx_controller: MSB-first and LSB-first instances share
// the same stimulus and are checked against a bit-stream reference.
module tb_sipo_rx_controller;

   logic        clk;
   logic        rst;
   logic        fs;
   logic        cont;
   logic        sv;
   logic        sd;
   logic        rdy;

   logic [31:0] dm, dl;
   logic        vm, vl;
   logic        bm, bl;
   logic [5:0]  cm, cl;
   logic        om, ol;

   int checks;
   int errors;

   logic        exp_v;
   logic [31:0] exp_m;
   logic [31:0] exp_l;

   sipo_rx_controller #(.WORD_WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
      .Clk_In         (clk),
      .Reset_In       (rst),
      .Frame_Start_In (fs),
      .Continuous_In  (cont),
      .Serial_Valid_In(sv),
      .Serial_Data_In (sd),
      .Word_Ready_In  (rdy),
      .Word_Data_Out  (dm),
      .Word_Valid_Out (vm),
      .Busy_Out       (bm),
      .Bit_Count_Out  (cm),
      .Overrun_Out    (om)
   );

   sipo_rx_controller #(.WORD_WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
      .Clk_In         (clk),
      .Reset_In       (rst),
      .Frame_Start_In (fs),
      .Continuous_In  (cont),
      .Serial_Valid_In(sv),
      .Serial_Data_In (sd),
      .Word_Ready_In  (rdy),
      .Word_Data_Out  (dl),
      .Word_Valid_Out (vl),
      .Busy_Out       (bl),
      .Bit_Count_Out  (cl),
      .Overrun_Out    (ol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst   = 1'b0;
      exp_v = 1'b0;
      exp_m = '0;
      exp_l = '0;
   endtask

   task automatic start_frame();
      fs = 1'b1;
      sv = 1'b1;
      sd = 1'($urandom);
      cyc();
      fs = 1'b0;
      sv = 1'b0;
      checks++;
      if (bm !== 1'b1 || bl !== 1'b1 || cm !== 6'd0 || cl !== 6'd0) begin
         errors++;
         $display("FAIL start: busy=%b/%b cnt=%0d/%0d want busy=1 cnt=0",
                  bm, bl, cm, cl);
      end
   endtask

   // Stream bit i of the word is w[31-i]; the reference word for
   // MSB-first is w itself, for LSB-first bit i lands in position i.
   task automatic send_word(input logic [31:0] w, input int gap,
                            input logic last_rdy);
      logic [31:0] rl;
      logic        load;
      for (int k = 0; k < 32; k++) rl[k] = w[31-k];
      for (int i = 0; i < 32; i++) begin
         while ($urandom_range(99) < gap) begin
            sv = 1'b0;
            sd = 1'($urandom);
            cyc();
            checks++;
            if (cm !== 6'(i) || cl !== 6'(i)) begin
               errors++;
               $display("FAIL gap_count: cnt=%0d/%0d want %0d", cm, cl, i);
            end
            checks++;
            if (vm !== exp_v || (exp_v && (dm !== exp_m || dl !== exp_l))) begin
               errors++;
               $display("FAIL hold: v=%b d=%h/%h want v=%b d=%h/%h",
                        vm, dm, dl, exp_v, exp_m, exp_l);
            end
         end
         sv = 1'b1;
         sd = w[31-i];
         if (i == 31) rdy = last_rdy;
         cyc();
         sv  = 1'b0;
         rdy = 1'b0;
         if (i < 31) begin
            checks++;
            if (cm !== 6'(i + 1) || cl !== 6'(i + 1)) begin
               errors++;
               $display("FAIL bit_count: cnt=%0d/%0d want %0d", cm, cl, i + 1);
            end
         end
      end
      load = !exp_v || last_rdy;
      if (load) begin
         exp_m = w;
         exp_l = rl;
      end
      exp_v = 1'b1;
      checks++;
      if (vm !== 1'b1 || vl !== 1'b1 || dm !== exp_m || dl !== exp_l) begin
         errors++;
         $display("FAIL word: v=%b/%b d=%h/%h want v=1 d=%h/%h",
                  vm, vl, dm, dl, exp_m, exp_l);
      end
      checks++;
      if (om !== !load || ol !== !load) begin
         errors++;
         $display("FAIL overrun: ovr=%b/%b want %b", om, ol, !load);
      end
      checks++;
      if (cm !== 6'd0 || cl !== 6'd0 || bm !== cont || bl !== cont) begin
         errors++;
         $display("FAIL complete: cnt=%0d/%0d busy=%b/%b want cnt=0 busy=%b",
                  cm, cl, bm, bl, cont);
      end
   endtask

   task automatic drain();
      rdy = 1'b1;
      cyc();
      rdy   = 1'b0;
      exp_v = 1'b0;
      checks++;
      if (vm !== 1'b0 || vl !== 1'b0) begin
         errors++;
         $display("FAIL drain: valid=%b/%b want 0", vm, vl);
      end
   endtask

   task automatic test_reset();
      fs   = 1'($urandom);
      sv   = 1'($urandom);
      sd   = 1'($urandom);
      rdy  = 1'($urandom);
      cont = 1'($urandom);
      do_reset();
      fs = 1'b0; sv = 1'b0; rdy = 1'b0; cont = 1'b0;
      checks++;
      if ({dm, vm, bm, cm, om} !== '0 || {dl, vl, bl, cl, ol} !== '0) begin
         errors++;
         $display("FAIL reset: m=%h %b %b %0d %b l=%h %b %b %0d %b want 0",
                  dm, vm, bm, cm, om, dl, vl, bl, cl, ol);
      end
   endtask

   task automatic test_known_word();
      do_reset();
      cont = 1'b0;
      start_frame();
      send_word(32'hA5C3_0F96, 0, 1'b0);
      checks++;
      if (dm !== 32'hA5C30F96 || dl !== 32'h69F0C3A5 || bm !== 1'b0) begin
         errors++;
         $display("FAIL known_word: d=%h/%h busy=%b want A5C30F96/69F0C3A5 0",
                  dm, dl, bm);
      end
      sv = 1'b0;
      cyc();
      checks++;
      if (vm !== 1'b1 || dm !== 32'hA5C30F96) begin
         errors++;
         $display("FAIL known_hold: v=%b d=%h want 1 A5C30F96", vm, dm);
      end
      drain();
   endtask

   task automatic test_gaps();
      do_reset();
      cont = 1'b0;
      for (int n = 0; n < 4; n++) begin
         start_frame();
         send_word($urandom, 50, 1'($urandom));
         drain();
      end
   endtask

   task automatic test_overrun();
      logic [31:0] a;
      do_reset();
      cont = 1'b1;
      a = $urandom;
      start_frame();
      send_word(a, 0, 1'b0);
      send_word($urandom, 30, 1'b0);
      cyc();
      checks++;
      if (om !== 1'b0 || ol !== 1'b0 || vm !== 1'b1 || dm !== a) begin
         errors++;
         $display("FAIL overrun_pulse: ovr=%b v=%b d=%h want 0 1 %h",
                  om, vm, dm, a);
      end
      send_word($urandom, 30, 1'b1);
      cont = 1'b0;
      drain();
   endtask

   task automatic test_abort();
      do_reset();
      cont = 1'b0;
      start_frame();
      for (int i = 0; i < 17; i++) begin
         sv = 1'b1;
         sd = 1'($urandom);
         cyc();
      end
      sv = 1'b0;
      checks++;
      if (cm !== 6'd17) begin
         errors++;
         $display("FAIL abort_pre: cnt=%0d want 17", cm);
      end
      start_frame();
      send_word($urandom, 20, 1'b0);
      drain();
   endtask

   task automatic test_back_to_back();
      do_reset();
      cont = 1'b1;
      start_frame();
      for (int n = 0; n < 3; n++) send_word($urandom, 10, 1'b1);
      cont = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      do_reset();
      cont = 1'b0;
      start_frame();
      send_word($urandom, 0, 1'b0);
      start_frame();
      for (int i = 0; i < 20; i++) begin
         sv = 1'b1;
         sd = 1'($urandom);
         cyc();
      end
      rst = 1'b1; sv = 1'b1; fs = 1'b1; rdy = 1'b0; cont = 1'b1;
      cyc();
      rst = 1'b0; sv = 1'b0; fs = 1'b0; cont = 1'b0;
      exp_v = 1'b0;
      checks++;
      if ({dm, vm, bm, cm, om} !== '0 || {dl, vl, bl, cl, ol} !== '0) begin
         errors++;
         $display("FAIL reset_mid: m=%h %b %b %0d %b want 0", dm, vm, bm, cm, om);
      end
      cyc();
      checks++;
      if (bm !== 1'b0 || om !== 1'b0 || vm !== 1'b0 || cm !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b ovr=%b v=%b cnt=%0d want 0",
                  bm, om, vm, cm);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0; fs = 1'b0; cont = 1'b0;
      sv = 1'b0; sd = 1'b0; rdy = 1'b0;
      exp_v = 1'b0; exp_m = '0; exp_l = '0;
      cyc();
      test_reset();
      test_known_word();
      test_gaps();
      test_overrun();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
